// File: rtl/sub_sliced.sv
// Slice-serial unsigned subtractor c = a - b, W = N/CC bits per clock, LS slice first.
// A borrow is chained across slices; start/done frame each N-bit operation.
module sub_sliced #(
   parameter  int N  = 128,
   parameter  int CC = 16,
   localparam int W  = N / CC,
   localparam int CW = (CC > 1) ? $clog2(CC) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic         c_valid,
   output logic         done,
   output logic         borrow_out,
   output logic         busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CW-1:0] LAST = CW'(CC - 1);

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic           borrow_q;
   logic [W-1:0]   c_q;
   logic           c_valid_q;
   logic           done_q;
   logic           borrow_out_q;

   logic           borrow_in;
   logic           borrow_d;
   logic [W-1:0]   diff_d;

   // A fresh operation always starts with no borrow, whatever borrow_q holds.
   always_comb begin
      borrow_in          = (state_q == RUN) ? borrow_q : 1'b0;
      {borrow_d, diff_d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         borrow_q     <= 1'b0;
         c_q          <= '0;
         c_valid_q    <= 1'b0;
         done_q       <= 1'b0;
         borrow_out_q <= 1'b0;
      end else begin
         c_valid_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  c_q       <= diff_d;
                  c_valid_q <= 1'b1;
                  if (CC == 1) begin
                     done_q       <= 1'b1;
                     borrow_out_q <= borrow_d;
                  end else begin
                     cnt_q    <= CW'(1);
                     borrow_q <= borrow_d;
                     state_q  <= RUN;
                  end
               end
            end
            RUN: begin
               c_q       <= diff_d;
               c_valid_q <= 1'b1;
               if (cnt_q == LAST) begin
                  done_q       <= 1'b1;
                  borrow_out_q <= borrow_d;
                  state_q      <= IDLE;
                  cnt_q        <= '0;
                  borrow_q     <= 1'b0;
               end else begin
                  cnt_q    <= cnt_q + CW'(1);
                  borrow_q <= borrow_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign c          = c_q;
   assign c_valid    = c_valid_q;
   assign done       = done_q;
   assign borrow_out = borrow_out_q;
   assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_sub_sliced.sv
// Randomized scoreboard bench for sub_sliced: full-width reference subtraction,
// expected slices queued by the driver and consumed by an independent monitor.
module tb_sub_sliced;
   localparam int N  = 128;
   localparam int CC = 16;
   localparam int W  = N / CC;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b, c;
   logic         c_valid, done, borrow_out, busy;

   logic         start2;
   logic [7:0]   a2, b2, c2;
   logic         c_valid2, done2, borrow_out2, busy2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] c;
      logic         done;
      logic         bo;
      int           cyc;
   } exp_t;
   exp_t q[$];

   sub_sliced #(.N(N), .CC(CC)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
      .c_valid(c_valid), .done(done), .borrow_out(borrow_out), .busy(busy)
   );

   sub_sliced #(.N(16), .CC(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2),
      .c_valid(c_valid2), .done(done2), .borrow_out(borrow_out2), .busy(busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every presented slice must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (c_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual c=%0h expected none (cycle %0d)", c, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("c_slice", 32'(c), 32'(e.c));
               chk("done_flag", 32'(done), 32'(e.done));
               chk("slice_cycle", 32'(cyc), 32'(e.cyc));
               if (e.done) chk("borrow_out", 32'(borrow_out), 32'(e.bo));
            end
         end else if (done) begin
            chk("done_without_valid", 32'(done), 32'd0);
         end
      end
   end

   function automatic logic [N-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one operation starting in the current cycle. stray: cycle index
   // at which an extra start is pulsed; abort: cycle index at which reset hits.
   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input int stray = -1, input int abort = -1);
      logic [N-1:0] d;
      logic         bo;
      exp_t         e;
      d  = av - bv;
      bo = (av < bv);
      for (int k = 0; k < CC; k++) begin
         if (k == abort) begin
            rst   = 1'b0;
            start = 1'b0;
            #1;
            chk("abort_c", 32'(c), 32'd0);
            chk("abort_valid", 32'(c_valid), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_bo", 32'(borrow_out), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            return;
         end
         // Slice k-1 of an aborted run is still only visible before reset hits.
         if (abort < 0 || k < abort - 1) begin
            e.c    = d[k*W +: W];
            e.done = (k == CC - 1);
            e.bo   = bo;
            e.cyc  = cyc + 1;
            q.push_back(e);
         end
         start = (k == 0) || (k == stray);
         a     = av[k*W +: W];
         b     = bv[k*W +: W];
         @(negedge clk);
         chk("busy", 32'(busy), 32'(k != 0));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      rst = 1'b0; start = 1'b0; a = '0; b = '0;
      start2 = 1'b0; a2 = '0; b2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_c", 32'(c), 32'd0);
      chk("rst_valid", 32'(c_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bo", 32'(borrow_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      idle(2);

      run_op(128'd5, 128'd3);
      idle(3);
      run_op(128'd1 << 64, 128'd1);
      idle(2);
      run_op(128'd0, 128'd1);
      run_op(128'd0, 128'd0);           // back-to-back in the done cycle
      idle(2);
      run_op(rnd(), rnd(), 5);          // stray start mid-run
      idle(2);
      run_op(rnd(), rnd(), -1, 7);      // reset mid-run
      idle(4);
      run_op(rnd(), rnd());
      for (int i = 0; i < 8; i++) begin
         ra = rnd();
         rb = (i % 3 == 0) ? ra : rnd();
         run_op(ra, rb);
         if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
      end
      run_op('1, '0);
      run_op('0, '1);
      idle(2);

      for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      // Small configuration: N=16, CC=2.
      start2 = 1'b1; a2 = 8'h34; b2 = 8'h35;
      @(posedge clk); #1;
      start2 = 1'b0; a2 = 8'h12; b2 = 8'h02;
      @(negedge clk);
      chk("n16_c0", 32'(c2), 32'hFF);
      chk("n16_v0", 32'(c_valid2), 32'd1);
      chk("n16_d0", 32'(done2), 32'd0);
      chk("n16_busy", 32'(busy2), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n16_c1", 32'(c2), 32'h0F);
      chk("n16_d1", 32'(done2), 32'd1);
      chk("n16_bo", 32'(borrow_out2), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n16_idle_valid", 32'(c_valid2), 32'd0);
      chk("n16_idle_done", 32'(done2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sub_sliced.md
Name: sub_sliced

Overview:
- Sequential N-bit subtractor computing c = a - b, one W = N/CC-bit slice per clock, least-significant slice first.
- A borrow register is carried between slices across CC cycles.
- Counterpart to the team's sliced sum block, reusing the same slice-streaming operand interface.
- Adds a start/done framing handshake so garbled-circuit test harnesses can run back-to-back operations.

Parameters:
- N, 128, total operand width in bits.
- CC, 16, number of clock cycles (slices) per operation. N must be divisible by CC; W = N/CC.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begins an operation; slice 0 is presented on a/b in the same cycle.
- a  input  W  minuend slice, LS slice first.
- b  input  W  subtrahend slice, LS slice first.
- c  output  W  registered difference slice.
- c_valid  output  1  c holds a new slice this cycle.
- done  output  1  one-cycle pulse coincident with c_valid of the last slice.
- borrow_out  output  1  final borrow of the full N-bit operation (1 means a < b unsigned); valid when done=1, held until the next start.
- busy  output  1  high while slices 1..CC-1 are being accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, slice counter=0, borrow=0, c=0, c_valid=0, done=0, borrow_out=0, busy=0.
- States: IDLE and RUN.
- IDLE with start=1:
  - consume a/b as slice 0 with borrow_in=0;
  - counter <= 1;
  - go to RUN, unless CC=1, in which case stay in IDLE and assert done next cycle.
- IDLE with start=0: c_valid=0, done=0, and c holds its last value.
- RUN, one slice per cycle, no stalls:
  - {borrow_next, diff} = {1'b0,a} - {1'b0,b} - borrow, computed in W+1 bits;
  - c <= diff, borrow <= borrow_next, c_valid <= 1, counter++.
- When counter = CC-1 (last slice):
  - at the clock edge, done <= 1 and borrow_out <= borrow_next;
  - state <= IDLE, counter <= 0, borrow <= 0.
- Latency: slice k is on c one cycle after it is presented. done asserts CC cycles after the start cycle (start at cycle 0, done at cycle CC).
- busy = (state==RUN), combinational from state.
- start while RUN is ignored; the operation continues unaffected.
- start in the cycle immediately after the last slice is accepted, i.e. the cycle where done=1, begins a new operation. There is no dead cycle between operations.
- Borrow always restarts at 0 on start. A stale borrow from a previous operation must never leak into the next one.
- Counter width is ceil(log2(CC)), minimum 1. The counter must not wrap past CC-1.
- Reset asserted mid-operation aborts immediately. After reset release the block waits in IDLE for a new start, and no done is produced for the aborted operation.
- Unsigned arithmetic only. Overflow is reported solely through borrow_out; c is the modulo-2^N result.

Test Plan:
- Defaults, a = 5, b = 3 (slice 0 a=0x05 b=0x03, all other slices 0x00), start at cycle 0 -> c=0x02 at cycle 1, then c=0x00 for slices 1..15; done and borrow_out=0 at cycle 16.
- Borrow ripple: a = 2^64 (slice 8 = 0x01, rest 0), b = 1 -> slices 0..7 c=0xFF, slice 8 c=0x00, slices 9..15 c=0x00; borrow_out=0.
- Underflow: a = 0, b = 1 -> every c slice = 0xFF; done with borrow_out=1.
- Back-to-back: start again in the done cycle of the underflow run with a=b=0 -> all c slices = 0x00 and borrow_out=0, proving the borrow was cleared; second done exactly 16 cycles after the second start.
- start pulsed at cycle 5 of a running operation -> ignored, and done still arrives at cycle 16. Separately, rst=0 at cycle 7 -> all outputs 0 immediately; no done until a fresh start, after which the result is correct.
- Override N=16, CC=2: a=0x1234, b=0x0235 -> c=0xFF at cycle 1, c=0x0F at cycle 2; done with borrow_out=0.
